// File: rtl/adder8_pkg.sv
// Shared types for the adder8 sequencing stage.
// The result record is what the output buffer stores and presents on out_*.
package adder8_pkg;

  localparam int ADD_W      = 8;
  localparam int OBUF_DEPTH = 2;

  typedef logic [ADD_W-1:0] add_word_t;

  typedef struct packed {
    add_word_t sum;
    logic      cout;
    logic      last;
  } result_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } seq_state_t;

endpackage

// File: rtl/adder8_res_fifo.sv
// Small result buffer: head entry is presented combinationally from storage.
// Push while full is accepted only when a pop frees the head in the same cycle.
module adder8_res_fifo
  import adder8_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  result_t push_data_i,
  input  logic    pop_i,
  output result_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;

  result_t          mem_q [OBUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(OBUF_DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/adder8_seq_ctrl.sv
// Sequencer around an external 8-bit ripple adder: launches one word, waits
// LATENCY cycles for the adder to settle, then captures s/cout into a 2-entry buffer.
//
//   state | meaning
//   IDLE  | add_* held, ready to launch when the buffer has a free slot
//   WAIT  | adder inputs stable, down-counter running to the capture edge
module adder8_seq_ctrl
  import adder8_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_cin,
  input  logic       in_chain,
  input  logic       in_last,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_c,
  input  logic [7:0] add_s,
  input  logic       add_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_cout,
  output logic       out_last,
  output logic       busy
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  seq_state_t state_q;
  logic [3:0] cnt_q;
  add_word_t  add_a_q;
  add_word_t  add_b_q;
  logic       add_c_q;
  logic       last_q;
  logic       carry_q;
  logic       live_q;

  logic       capture;
  logic       launch;
  logic       buf_full;
  logic       buf_empty;
  result_t    push_data;
  result_t    head;

  // live_q keeps in_ready low while reset is held and for the release cycle.
  assign in_ready  = live_q && (state_q == IDLE) && !buf_full;
  assign launch    = in_valid && in_ready;
  assign capture   = (state_q == WAIT) && (cnt_q == '0);
  assign busy      = (state_q != IDLE);

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_c     = add_c_q;

  assign push_data = '{sum: add_s, cout: add_cout, last: last_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
      add_c_q <= 1'b0;
      last_q  <= 1'b0;
      carry_q <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (launch) begin
            add_a_q <= in_a;
            add_b_q <= in_b;
            add_c_q <= in_chain ? carry_q : in_cin;
            last_q  <= in_last;
            cnt_q   <= CNT_INIT;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // A last word ends the chain, so the next chained word starts from zero.
            carry_q <= last_q ? 1'b0 : add_cout;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  adder8_res_fifo u_res_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (capture),
    .push_data_i (push_data),
    .pop_i       (out_valid && out_ready),
    .head_o      (head),
    .full_o      (buf_full),
    .empty_o     (buf_empty)
  );

  assign out_valid = !buf_empty;
  assign out_sum   = head.sum;
  assign out_cout  = head.cout;
  assign out_last  = head.last;

endmodule

// File: tb/tb_adder8_seq_ctrl.sv
// Bench for adder8_seq_ctrl: LATENCY=4 and LATENCY=1 instances, each with a
// behavioural 8-bit adder attached, checked against a queue-based word model.
module tb_adder8_seq_ctrl;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       chain;
    logic       last;
  } word_t;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       last;
    int         due;
  } res_t;

  logic       clk;
  logic       rst_n;

  logic       in_valid, in_ready, in_cin, in_chain, in_last;
  logic [7:0] in_a, in_b, add_a, add_b, add_s, out_sum;
  logic       add_c, add_cout, out_valid, out_ready, out_cout, out_last, busy;

  logic       in_valid1, in_ready1, in_cin1, in_chain1, in_last1;
  logic [7:0] in_a1, in_b1, add_a1, add_b1, add_s1, out_sum1;
  logic       add_c1, add_cout1, out_valid1, out_ready1, out_cout1, out_last1, busy1;

  int checks   = 0;
  int failures = 0;

  word_t      pend[$];
  res_t       expq[$];
  logic       carry_m;
  logic       launch_chk;
  logic [7:0] la, lb;
  logic       lc;
  logic       hold_chk;
  logic [9:0] held;
  logic       acc_now;

  assign {add_cout, add_s}   = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_c};
  assign {add_cout1, add_s1} = {1'b0, add_a1} + {1'b0, add_b1} + {8'd0, add_c1};

  adder8_seq_ctrl #(.LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_chain(in_chain), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_last(out_last), .busy(busy)
  );

  adder8_seq_ctrl #(.LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
    .in_cin(in_cin1), .in_chain(in_chain1), .in_last(in_last1),
    .add_a(add_a1), .add_b(add_b1), .add_c(add_c1), .add_s(add_s1), .add_cout(add_cout1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
    .out_cout(out_cout1), .out_last(out_last1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic word_t mk(input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic chain, input logic last);
    word_t w;
    w.a = a; w.b = b; w.cin = cin; w.chain = chain; w.last = last;
    return w;
  endfunction

  task automatic clear_model();
    pend.delete();
    expq.delete();
    carry_m    = 1'b0;
    launch_chk = 1'b0;
    hold_chk   = 1'b0;
    acc_now    = 1'b0;
    in_valid   = 1'b0;
  endtask

  // One cycle on the LATENCY=4 instance: checks the previous launch and
  // output stability, drives the next pending word, scores pops and accepts.
  task automatic tick(input bit rdy);
    word_t      w;
    res_t       e;
    logic       cin;
    logic [8:0] s;
    @(negedge clk);
    if (launch_chk) begin
      checks++;
      if (add_a !== la || add_b !== lb || add_c !== lc) begin
        failures++;
        $display("FAIL launch_regs: got a=%h b=%h c=%b want a=%h b=%h c=%b", add_a, add_b, add_c, la, lb, lc);
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_wait: got %b want 1", busy);
      end
      launch_chk = 1'b0;
    end
    if (hold_chk) begin
      checks++;
      if ({out_valid, out_sum, out_cout, out_last} !== {1'b1, held}) begin
        failures++;
        $display("FAIL out_stable: got v=%b %h/%b/%b want v=1 %h/%b/%b", out_valid, out_sum, out_cout,
                 out_last, held[9:2], held[1], held[0]);
      end
    end
    out_ready = rdy;
    if (pend.size() > 0) begin
      in_valid = 1'b1;
      in_a = pend[0].a; in_b = pend[0].b; in_cin = pend[0].cin;
      in_chain = pend[0].chain; in_last = pend[0].last;
    end else begin
      in_valid = 1'b0;
    end
    #1;
    hold_chk = out_valid && !out_ready;
    held     = {out_sum, out_cout, out_last};
    acc_now  = 1'b0;
    if (out_valid && out_ready) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: got %h/%b with nothing outstanding", out_sum, out_cout);
      end else begin
        e = expq.pop_front();
        if (out_sum !== e.sum || out_cout !== e.cout || out_last !== e.last) begin
          failures++;
          $display("FAIL result: got %h/%b/%b want %h/%b/%b", out_sum, out_cout, out_last, e.sum, e.cout, e.last);
        end
      end
    end
    if (in_valid && in_ready) begin
      w   = pend.pop_front();
      cin = w.chain ? carry_m : w.cin;
      s   = {1'b0, w.a} + {1'b0, w.b} + {8'd0, cin};
      e.sum = s[7:0]; e.cout = s[8]; e.last = w.last; e.due = 0;
      expq.push_back(e);
      carry_m    = w.last ? 1'b0 : s[8];
      launch_chk = 1'b1;
      la = w.a; lb = w.b; lc = cin;
      acc_now = 1'b1;
    end
  endtask

  task automatic run_until_done(input bit random_rdy, input int budget);
    int n = 0;
    while ((pend.size() > 0 || expq.size() > 0 || launch_chk) && n < budget) begin
      tick(random_rdy ? ($urandom_range(3) != 0) : 1'b1);
      n++;
    end
    checks++;
    if (pend.size() > 0 || expq.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout: pending=%0d outstanding=%0d after %0d cycles", pend.size(), expq.size(), n);
    end
  endtask

  task automatic wait_accept(input bit rdy, input int budget);
    int n = 0;
    acc_now = 1'b0;
    while (!acc_now && n < budget) begin
      tick(rdy);
      n++;
    end
    checks++;
    if (!acc_now) begin
      failures++;
      $display("FAIL accept_timeout: got no accept want accept within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_model();
    out_ready = 1'b1; in_a = '0; in_b = '0; in_cin = 0; in_chain = 0; in_last = 0;
    in_valid1 = 0; out_ready1 = 1; in_a1 = '0; in_b1 = '0; in_cin1 = 0; in_chain1 = 0; in_last1 = 0;
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || in_ready1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready: got %b/%b want 0/0", in_ready, in_ready1);
    end
    checks++;
    if ({out_valid, busy, out_sum, out_cout, out_last} !== 12'd0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b busy=%b %h/%b/%b want all 0", out_valid, busy, out_sum, out_cout, out_last);
    end
    checks++;
    if ({add_a, add_b, add_c} !== 17'd0) begin
      failures++;
      $display("FAIL reset_add: got %h %h %b want 0 0 0", add_a, add_b, add_c);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick(1'b1);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || in_ready1 !== 1'b1) begin
      failures++;
      $display("FAIL idle_after_reset: got in_ready=%b busy=%b in_ready1=%b want 1 0 1", in_ready, busy, in_ready1);
    end
  endtask

  task automatic test_single();
    pend.push_back(mk(8'h3C, 8'h05, 1'b1, 1'b0, 1'b1));
    wait_accept(1'b1, 10);
    for (int k = 1; k <= 6; k++) begin
      tick(1'b1);
      if (k <= 4) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
          failures++;
          $display("FAIL single_wait k=%0d: got in_ready=%b out_valid=%b want 0 0", k, in_ready, out_valid);
        end
      end else if (k == 5) begin
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'h42 || out_cout !== 1'b0 || in_ready !== 1'b1) begin
          failures++;
          $display("FAIL single_result: got v=%b %h/%b rdy=%b want v=1 42/0 rdy=1", out_valid, out_sum, out_cout, in_ready);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL single_popped: got out_valid=%b want 0", out_valid);
        end
      end
    end
    run_until_done(1'b0, 20);
  endtask

  task automatic test_chain();
    pend.push_back(mk(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0));
    pend.push_back(mk(8'h00, 8'h00, 1'b0, 1'b1, 1'b1));
    pend.push_back(mk(8'h00, 8'h00, 1'b1, 1'b1, 1'b1));
    run_until_done(1'b0, 60);
  endtask

  task automatic test_backpressure();
    pend.push_back(mk(8'h01, 8'h01, 1'b0, 1'b0, 1'b1));
    pend.push_back(mk(8'h02, 8'h02, 1'b0, 1'b0, 1'b1));
    pend.push_back(mk(8'h03, 8'h03, 1'b0, 1'b0, 1'b1));
    repeat (20) tick(1'b0);
    checks++;
    if (pend.size() != 1) begin
      failures++;
      $display("FAIL bp_accepts: got %0d accepted want 2", 3 - pend.size());
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b1 || out_sum !== 8'h02) begin
      failures++;
      $display("FAIL bp_state: got rdy=%b busy=%b v=%b sum=%h want 0 0 1 02", in_ready, busy, out_valid, out_sum);
    end
    run_until_done(1'b0, 60);
  endtask

  task automatic test_push_pop();
    int n = 0;
    pend.push_back(mk(8'h05, 8'h06, 1'b0, 1'b0, 1'b1));
    while (!(out_valid === 1'b1 && pend.size() == 0) && n < 20) begin
      tick(1'b0);
      n++;
    end
    pend.push_back(mk(8'h07, 8'h08, 1'b0, 1'b0, 1'b1));
    wait_accept(1'b0, 10);
    for (int k = 1; k <= 3; k++) tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'h0F || in_ready !== 1'b1 || expq.size() != 1) begin
      failures++;
      $display("FAIL push_pop: got v=%b sum=%h rdy=%b outstanding=%0d want 1 0f 1 1", out_valid, out_sum,
               in_ready, expq.size());
    end
    run_until_done(1'b0, 20);
  endtask

  task automatic test_reset_mid();
    pend.push_back(mk(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0));
    run_until_done(1'b0, 30);
    pend.push_back(mk(8'h11, 8'h22, 1'b0, 1'b0, 1'b0));
    wait_accept(1'b1, 10);
    tick(1'b1);
    tick(1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b000 || {add_a, add_b, add_c} !== 17'd0) begin
      failures++;
      $display("FAIL mid_reset: got v=%b busy=%b rdy=%b add=%h/%h/%b want all 0", out_valid, busy, in_ready,
               add_a, add_b, add_c);
    end
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) tick(1'b1);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL after_mid_reset: got v=%b busy=%b want 0 0", out_valid, busy);
    end
    pend.push_back(mk(8'h10, 8'h20, 1'b0, 1'b1, 1'b1));
    run_until_done(1'b0, 30);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      pend.push_back(mk(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(2) == 0)));
    end
    run_until_done(1'b1, 2000);
  endtask

  task automatic test_lat1();
    word_t      w1[$];
    res_t       e1[$];
    res_t       e;
    word_t      w;
    logic       carry1;
    logic       cin;
    logic [8:0] s;
    int         last_acc;
    int         c;
    w1.push_back(mk(8'h80, 8'h80, 1'b0, 1'b0, 1'b1));
    w1.push_back(mk(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1));
    w1.push_back(mk(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0));
    w1.push_back(mk(8'h7F, 8'h00, 1'b0, 1'b1, 1'b1));
    w1.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 6; i++) begin
      w1.push_back(mk(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)));
    end
    carry1   = 1'b0;
    last_acc = -1;
    c        = 0;
    while ((w1.size() > 0 || e1.size() > 0) && c < 100) begin
      @(negedge clk);
      out_ready1 = 1'b1;
      if (w1.size() > 0) begin
        in_valid1 = 1'b1;
        in_a1 = w1[0].a; in_b1 = w1[0].b; in_cin1 = w1[0].cin;
        in_chain1 = w1[0].chain; in_last1 = w1[0].last;
      end else begin
        in_valid1 = 1'b0;
      end
      #1;
      if (e1.size() > 0 && e1[0].due == c) begin
        e = e1.pop_front();
        checks++;
        if (out_valid1 !== 1'b1 || out_sum1 !== e.sum || out_cout1 !== e.cout || out_last1 !== e.last) begin
          failures++;
          $display("FAIL lat1_result: got v=%b %h/%b/%b want v=1 %h/%b/%b", out_valid1, out_sum1, out_cout1,
                   out_last1, e.sum, e.cout, e.last);
        end
      end else if (out_valid1 === 1'b1) begin
        checks++;
        failures++;
        $display("FAIL lat1_unexpected: got result %h/%b at cycle %0d want none", out_sum1, out_cout1, c);
      end
      if (in_valid1 && in_ready1) begin
        if (last_acc >= 0) begin
          checks++;
          if (c - last_acc != 2) begin
            failures++;
            $display("FAIL lat1_accept_gap: got %0d cycles want 2", c - last_acc);
          end
        end
        last_acc = c;
        w   = w1.pop_front();
        cin = w.chain ? carry1 : w.cin;
        s   = {1'b0, w.a} + {1'b0, w.b} + {8'd0, cin};
        e.sum = s[7:0]; e.cout = s[8]; e.last = w.last; e.due = c + 2;
        e1.push_back(e);
        carry1 = w.last ? 1'b0 : s[8];
      end
      c++;
    end
    in_valid1 = 1'b0;
    checks++;
    if (w1.size() > 0 || e1.size() > 0) begin
      failures++;
      $display("FAIL lat1_timeout: got %0d words %0d results left want 0 0", w1.size(), e1.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_chain();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    test_random();
    test_lat1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder8_seq_ctrl.md
Name: adder8_seq_ctrl

Overview:
- Sequencing stage wrapped around the 8-bit ripple adder netlist (`top`: a_*/b_*/c in, s_*/cout out).
- Upstream side: accepts operand words over a valid/ready handshake and launches one addition at a time.
- Holds the adder inputs stable for the adder's balanced logic depth, then samples s/cout into a 2-entry output buffer.
- Supports multi-word (chained) addition by feeding back the captured carry.

Parameters:
- LATENCY, 4, cycles from adder-input launch to result sample; legal range 1..15.
- OBUF_DEPTH, 2, output buffer entries; fixed at 2 in this revision.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand word offered
- in_ready  out  1  block accepts word this cycle
- in_a  in  8  operand A
- in_b  in  8  operand B
- in_cin  in  1  carry-in used when in_chain=0
- in_chain  in  1  1: use stored carry from previous word instead of in_cin
- in_last  in  1  last word of a multi-word operation
- add_a  out  8  to adder a_7_..a_0_
- add_b  out  8  to adder b_7_..b_0_
- add_c  out  1  to adder c
- add_s  in  8  from adder s_7_..s_0_
- add_cout  in  1  from adder cout
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_sum  out  8  result sum
- out_cout  out  1  result carry-out
- out_last  out  1  echo of in_last for this word
- busy  out  1  operation in flight (state != IDLE)

Behaviour:
- Reset (async assert, sync-released by system):
  - state=IDLE; add_a=0, add_b=0, add_c=0; carry_reg=0.
  - Buffer empty: out_valid=0, out_sum=0, out_cout=0, out_last=0; busy=0.
  - in_ready=0 while rst_n low.
- States: IDLE, WAIT.
- in_ready = (state==IDLE) && (buffer occupancy < 2), combinational from registers only; no dependence on in_valid.
- Launch: on in_valid&&in_ready at edge t:
  - register add_a=in_a, add_b=in_b.
  - add_c = in_chain ? carry_reg : in_cin.
  - latch last_r=in_last; cnt=LATENCY-1; state->WAIT.
- WAIT:
  - add_a/add_b/add_c held constant.
  - If cnt!=0, decrement.
  - If cnt==0 at an edge: push {add_s, add_cout, last_r} into the buffer; carry_reg = last_r ? 0 : add_cout; state->IDLE.
  - That edge is LATENCY cycles after the launch edge.
- Timing: the result is visible (out_valid=1) in the cycle after the capture edge. in_ready re-asserts in the same cycle if a slot is free. Peak throughput: one word per LATENCY+1 cycles.
- add_* outputs keep their last values in IDLE; no glitching, since they are registered only.
- Output buffer: 2-entry FIFO with head on out_*.
  - Pop on out_valid&&out_ready.
  - Simultaneous push and pop: occupancy unchanged, order preserved.
  - Push never occurs when full, guaranteed by in_ready gating at launch.
- Chaining:
  - carry_reg holds the cout of the most recent non-last word.
  - in_chain=1 on the first word after reset or after a last word yields add_c=0.
- Arithmetic: {out_cout,out_sum} = in_a + in_b + carry_in, 9-bit, no saturation. The block computes nothing itself; it relies on the adder.
- Mid-operation reset: in-flight word dropped, buffer flushed, carry_reg cleared; no output produced for it.
- out_* hold stable while out_valid&&!out_ready (AXI-style stability).

Decomposition:
- Shared package adder8_pkg:
  - constant ADD_W=8.
  - typedef add_word_t (logic [7:0]).
  - typedef result_t (struct: sum, cout, last).
  - enum seq_state_t {IDLE, WAIT}.
- One sub-module: adder8_res_fifo (2-entry result_t FIFO with push/pop/full/empty).
- The adder netlist is instantiated by the parent, not inside this block.

Test Plan:
- Single word: a=0x3C, b=0x05, cin=1, chain=0, LATENCY=4, adder model attached, out_ready=1.
  - Expect add_c=1 one cycle after accept; out_sum=0x42, out_cout=0 valid exactly 5 cycles after accept; in_ready low for 4 cycles.
- Two-word chain: word0 a=0xFF, b=0x01, cin=0, last=0; word1 a=0x00, b=0x00, chain=1, last=1.
  - Expect out 0x00/cout=1, then add_c=1 on word1 and out 0x01/cout=0.
  - carry_reg=0 afterwards; a third word with chain=1 yields add_c=0.
- Backpressure: out_ready=0, offer 3 words (1+1, 2+2, 3+3).
  - Expect two results buffered, in_ready stuck 0 after the second capture, out_sum=0x02 held stable.
  - Release out_ready: results 0x02, 0x04 pop in order; third word then launches, giving 0x06.
- Simultaneous push/pop: buffer holds 1 entry, out_ready=1 on the capture edge.
  - Expect occupancy stays 1, correct order, no lost or duplicated results.
- Reset mid-op: assert rst_n=0 two cycles into WAIT.
  - Expect immediate out_valid=0, busy=0, add_a=0, carry_reg=0; no result after release; next word 0x10+0x20 gives 0x30.
- LATENCY=1 build: back-to-back in_valid.
  - Expect accept every 2nd cycle, results 1 cycle after capture, all 8-bit wrap cases (0x80+0x80 → 0x00, cout=1) correct.
